// File: rtl/fixed_sqrt_iter.sv
// fixed_sqrt_iter: iterative fixed-point square root, signed Q(WIDTH-FRAC).FRAC.
// Computes the integer root of (a << FRAC) with a non-restoring digit recurrence,
// BPC root bits per clock. Negative radicands finish immediately with err=1.
// Optional feature macro: SQRT_ROUND_EN (round-to-nearest on the final write;
// the default build truncates).
module fixed_sqrt_iter #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int BPC   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             err
);
    localparam int N    = WIDTH + FRAC;            // radicand width after scaling
    localparam int ITER = N / 2;                   // root bits
    localparam int CYC  = (BPC > 0) ? ITER / BPC : 1;
    localparam int CW   = (CYC > 1) ? $clog2(CYC) : 1;
    localparam int REMW = ITER + 2;                // signed partial remainder

    // Elaboration-time legality of the parameter set
    if (FRAC <= 0 || FRAC >= WIDTH) begin : g_bad_frac
        $error("fixed_sqrt_iter: FRAC must satisfy 0 < FRAC < WIDTH");
    end
    if ((N % 2) != 0) begin : g_bad_even
        $error("fixed_sqrt_iter: WIDTH+FRAC must be even");
    end
    if (BPC < 1 || (ITER % BPC) != 0) begin : g_bad_bpc
        $error("fixed_sqrt_iter: (WIDTH+FRAC)/2 must be a multiple of BPC");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_nx;
    logic [N-1:0]      rad, rad_nx;     // remaining radicand digits, MSB pair first
    logic [ITER-1:0]   q, q_nx;         // partial root
    logic [REMW-1:0]   rem, rem_nx;     // partial remainder, two's complement
    logic [CW-1:0]     cnt, cnt_nx;
    logic [WIDTH-1:0]  b_nx;
    logic              err_nx;

    logic [N-1:0]      rad_s;
    logic [ITER-1:0]   q_s;
    logic [REMW-1:0]   rem_s;
    logic [REMW-1:0]   wide;
    logic [WIDTH-1:0]  res;

    // BPC non-restoring digit steps: subtract {q,01} while the remainder is
    // non-negative, otherwise add {q,11}; the new root bit is the inverted sign.
    // The remainder stays within +/-2^(ITER+1), so REMW-bit modular math is exact.
    always_comb begin
        rad_s = rad;
        q_s   = q;
        rem_s = rem;
        wide  = '0;
        for (int i = 0; i < BPC; i++) begin
            wide = (rem_s << 2) | REMW'(rad_s[N-1 -: 2]);
            if (!rem_s[REMW-1])
                wide = wide - REMW'({q_s, 2'b01});
            else
                wide = wide + REMW'({q_s, 2'b11});
            rem_s = wide;
            q_s   = {q_s[ITER-2:0], ~wide[REMW-1]};
            rad_s = rad_s << 2;
        end
    end

`ifdef SQRT_ROUND_EN
    logic [REMW-1:0] rfix;

    // Round to nearest: fix up a negative final remainder to r = R - q^2,
    // then bump the root when r > q (sqrt(R) > q + 0.5; ties cannot occur).
    always_comb begin
        rfix = rem_s;
        if (rem_s[REMW-1])
            rfix = rem_s + REMW'({q_s, 1'b1});
        res = WIDTH'(q_s);
        if (rfix > REMW'(q_s))
            res = WIDTH'(q_s) + WIDTH'(1);
    end
`else
    // Truncation: the root is floor(sqrt(R)), zero-extended.
    assign res = WIDTH'(q_s);
`endif

    // Next-state and datapath update; start is only honoured in IDLE.
    always_comb begin
        state_nx = state;
        rad_nx   = rad;
        q_nx     = q;
        rem_nx   = rem;
        cnt_nx   = cnt;
        b_nx     = b;
        err_nx   = err;
        case (state)
            IDLE: begin
                if (start) begin
                    if (a[WIDTH-1]) begin
                        b_nx     = '0;
                        err_nx   = 1'b1;
                        state_nx = DONE;
                    end else begin
                        rad_nx   = {a, {FRAC{1'b0}}};
                        q_nx     = '0;
                        rem_nx   = '0;
                        cnt_nx   = CW'(CYC - 1);
                        state_nx = CALC;
                    end
                end
            end
            CALC: begin
                rad_nx = rad_s;
                q_nx   = q_s;
                rem_nx = rem_s;
                cnt_nx = cnt - CW'(1);
                if (cnt == '0) begin
                    b_nx     = res;
                    err_nx   = 1'b0;
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State and datapath registers; busy/ready registered from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            rad   <= '0;
            q     <= '0;
            rem   <= '0;
            cnt   <= '0;
            b     <= '0;
            err   <= 1'b0;
            busy  <= 1'b0;
            ready <= 1'b0;
        end else begin
            state <= state_nx;
            rad   <= rad_nx;
            q     <= q_nx;
            rem   <= rem_nx;
            cnt   <= cnt_nx;
            b     <= b_nx;
            err   <= err_nx;
            busy  <= (state_nx != IDLE);
            ready <= (state_nx == DONE);
        end
    end
endmodule

// File: tb/tb_fixed_sqrt_iter.sv
// Scoreboard bench for fixed_sqrt_iter (WIDTH=32, FRAC=16; BPC selectable).
// Stimulus pushes the expected {b,err} when it issues a start; a monitor pops
// and compares on every ready pulse. Define SQRT_ROUND_EN for the rounding build.
module tb_fixed_sqrt_iter #(
    parameter int BPC = 1
);
    localparam int LAT = 24 / BPC;

`ifdef SQRT_ROUND_EN
    localparam logic [31:0] SQ2 = 32'h0001_6A0A;
    localparam logic [31:0] SQ3 = 32'h0001_BB68;
`else
    localparam logic [31:0] SQ2 = 32'h0001_6A09;
    localparam logic [31:0] SQ3 = 32'h0001_BB67;
`endif

    typedef struct {
        logic [31:0] b;
        logic        err;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a     = '0;
    logic [31:0] b;
    logic        ready, busy, err;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    fixed_sqrt_iter #(.WIDTH(32), .FRAC(16), .BPC(BPC)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .err   (err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && ready) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_ready: got b=%h err=%b expected no result", b, err);
            end else begin
                e = sb.pop_front();
                chk("result_b", b, e.b);
                chk("result_err", {31'b0, err}, {31'b0, e.err});
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || ready) && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) begin
            checks++;
            $display("FAIL idle_timeout: got busy=%b expected 0", busy);
        end
    endtask

    // One operation; latency counts edges after the accepting edge until ready.
    task automatic run(input logic [31:0] av, input logic [31:0] eb, input logic ee,
                       input bit poke);
        int lat;
        wait_idle();
        sb.push_back('{eb, ee});
        @(negedge clock);
        start = 1'b1;
        a     = av;
        @(posedge clock);
        #1;
        start = 1'b0;
        a     = 32'hDEAD_BEEF;
        @(negedge clock);
        chk("busy_after_start", {31'b0, busy}, 32'd1);
        lat = 0;
        while (!ready && lat < 200) begin
            start = (poke && lat == 2);
            if (poke && lat == 2) a = 32'h0009_0000;
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        chk("latency", lat, ee ? 32'd0 : LAT);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("rst_b", b, 32'h0);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        run(32'h0004_0000, 32'h0002_0000, 1'b0, 1'b0);   // 4.0  -> 2.0
        run(32'h0002_0000, SQ2,           1'b0, 1'b0);   // 2.0  -> 1.41421
        run(32'h0000_4000, 32'h0000_8000, 1'b0, 1'b0);   // 0.25 -> 0.5
        run(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);   // 0
        run(32'hFFFE_0000, 32'h0000_0000, 1'b1, 1'b0);   // -2.0 -> err
        run(32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0);   // 1.0  -> 1.0
        run(32'h0002_4000, 32'h0001_8000, 1'b0, 1'b0);   // 2.25 -> 1.5
        run(32'h0003_0000, SQ3,           1'b0, 1'b0);   // 3.0  -> 1.73205
        run(32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0);   // 2^-16 -> 2^-8
        run(32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0);   // most negative
        run(32'h4000_0000, 32'h0080_0000, 1'b0, 1'b0);   // 16384.0 -> 128.0
        run(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);   // -2^-16
        run(32'h0004_0000, 32'h0002_0000, 1'b0, 1'b1);   // mid-CALC start ignored
        run(32'h0009_0000, 32'h0003_0000, 1'b0, 1'b0);   // 9.0 -> 3.0

        // Abort in CALC: no ready, outputs cleared, then a fresh op works.
        wait_idle();
        @(negedge clock);
        start = 1'b1;
        a     = 32'h0004_0000;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("abort_b", b, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_ready", {31'b0, ready}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (LAT + 5) @(negedge clock);
        run(32'h0002_4000, 32'h0001_8000, 1'b0, 1'b0);

        wait_idle();
        repeat (5) @(negedge clock);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
